// File: rtl/vga_scan_gen_if.sv
// Scan-timing bundle produced by vga_scan_gen.
//   master : driven by the scan generator
//   slave  : read by the pixel/sprite pipeline
// Members:
//   DrawX, DrawY : current raster position (registered counters)
//   show_base    : position lies in the 32x32 base window
//   hs, vs       : active-low syncs, one cycle behind the position
//   display_en   : visible-pixel flag, one cycle behind the position
//   frame_end    : one-cycle pulse when the raster wraps to (0,0)
//   frame_count  : completed frames, modulo 256
interface vga_scan_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       show_base;
  logic       hs;
  logic       vs;
  logic       display_en;
  logic       frame_end;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, show_base, hs, vs, display_en, frame_end, frame_count
  );

  modport slave (
    input DrawX, DrawY, show_base, hs, vs, display_en, frame_end, frame_count
  );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator.
// Ports:
//   vga_clk : pixel clock, all state advances on its rising edge
//   reset   : asynchronous, active-high
//   scan    : vga_scan_gen_if master modport carrying position, window flag,
//             pipeline-aligned syncs/enable and frame bookkeeping
module vga_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int BASE_X    = 304,
  parameter int BASE_Y    = 448
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_scan_gen_if.master   scan
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Window and sync bounds are held in 11 bits so that BASE+31 or the end of
  // the sync interval cannot wrap when compared against a 10-bit counter.
  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_STOP  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_STOP  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] WX_LO    = 11'(BASE_X);
  localparam logic [10:0] WX_HI    = 11'(BASE_X + 31);
  localparam logic [10:0] WY_LO    = 11'(BASE_Y);
  localparam logic [10:0] WY_HI    = 11'(BASE_Y + 31);

  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic       hs_q;
  logic       vs_q;
  logic       de_q;
  logic       frame_end_q;
  logic [7:0] frame_count_q;

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        line_end;
  logic        frame_wrap;
  logic        hs_raw;
  logic        vs_raw;
  logic        de_raw;

  assign x_ext      = {1'b0, draw_x};
  assign y_ext      = {1'b0, draw_y};
  assign line_end   = (x_ext == X_LAST);
  assign frame_wrap = line_end && (y_ext == Y_LAST);

  assign hs_raw = !((x_ext >= HS_START) && (x_ext < HS_STOP));
  assign vs_raw = !((y_ext >= VS_START) && (y_ext < VS_STOP));
  assign de_raw = (x_ext < H_VIS) && (y_ext < V_VIS);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      draw_x        <= '0;
      draw_y        <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      de_q          <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      if (line_end) begin
        draw_x <= '0;
        if (y_ext == Y_LAST) draw_y <= '0;
        else                 draw_y <= draw_y + 10'd1;
      end else begin
        draw_x <= draw_x + 10'd1;
      end
      // Syncs and enable are decoded from the current position and then
      // registered, landing one cycle late to match the registered RGB path.
      hs_q <= hs_raw;
      vs_q <= vs_raw;
      de_q <= de_raw;
      // The pulse and count change together as the counters move to (0,0);
      // the post-reset (0,0) never passed through the last position, so no pulse.
      frame_end_q <= frame_wrap;
      if (frame_wrap) frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign scan.DrawX       = draw_x;
  assign scan.DrawY       = draw_y;
  assign scan.show_base   = (x_ext >= WX_LO) && (x_ext <= WX_HI) &&
                            (y_ext >= WY_LO) && (y_ext <= WY_HI);
  assign scan.hs          = hs_q;
  assign scan.vs          = vs_q;
  assign scan.display_en  = de_q;
  assign scan.frame_end   = frame_end_q;
  assign scan.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen. Three instances share one clock:
//   a : default 640x480 timing (line behaviour, async reset mid-line)
//   b : shrunken timing with a small base window (window edges)
//   c : tiny 7x7 raster (many frames, frame_count wrap)
// A cycle-count model predicts every output of every instance each negedge.
module tb_vga_scan_gen;
  logic clk = 1'b0;
  logic rst_a;
  logic rst;

  always #5 clk = ~clk;

  vga_scan_gen_if if_a ();
  vga_scan_gen_if if_b ();
  vga_scan_gen_if if_c ();

  vga_scan_gen dut_a (.vga_clk(clk), .reset(rst_a), .scan(if_a));

  vga_scan_gen #(
    .H_VISIBLE(40), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(36), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .BASE_X(4), .BASE_Y(2)
  ) dut_b (.vga_clk(clk), .reset(rst), .scan(if_b));

  vga_scan_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .BASE_X(0), .BASE_Y(0)
  ) dut_c (.vga_clk(clk), .reset(rst), .scan(if_c));

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Rising edges seen since the last reset, per instance.
  longint n_a, n_b, n_c;
  always @(posedge clk or posedge rst_a) if (rst_a) n_a <= 0; else n_a <= n_a + 1;
  always @(posedge clk or posedge rst)   if (rst)   n_b <= 0; else n_b <= n_b + 1;
  always @(posedge clk or posedge rst)   if (rst)   n_c <= 0; else n_c <= n_c + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // After n edges the raster sits at position n (row-major, modulo a frame);
  // the delayed outputs reflect position n-1, and nothing is pending at n=0.
  task automatic model_check(input string nm,
                             input int hv, input int hf, input int hsw, input int hb,
                             input int vv, input int vf, input int vsw, input int vb,
                             input int bx, input int by, input longint n,
                             input logic [9:0] dx, input logic [9:0] dy,
                             input logic sb, input logic h, input logic v,
                             input logic de, input logic fe, input logic [7:0] fc);
    longint ht, vt, fr, ex, ey, px, py;
    logic esb, eh, ev, ede, efe;
    longint efc;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    fr = ht * vt;
    ex = n % ht;
    ey = (n / ht) % vt;
    esb = (ex >= bx) && (ex <= bx + 31) && (ey >= by) && (ey <= by + 31);
    if (n == 0) begin
      eh = 1'b1; ev = 1'b1; ede = 1'b0; efe = 1'b0; efc = 0;
    end else begin
      px  = (n - 1) % ht;
      py  = ((n - 1) / ht) % vt;
      eh  = !(px >= hv + hf && px < hv + hf + hsw);
      ev  = !(py >= vv + vf && py < vv + vf + vsw);
      ede = (px < hv) && (py < vv);
      efe = (n % fr) == 0;
      efc = (n / fr) % 256;
    end
    cmp({nm, ".DrawX"},       32'(dx),  32'(ex));
    cmp({nm, ".DrawY"},       32'(dy),  32'(ey));
    cmp({nm, ".show_base"},   32'(sb),  32'(esb));
    cmp({nm, ".hs"},          32'(h),   32'(eh));
    cmp({nm, ".vs"},          32'(v),   32'(ev));
    cmp({nm, ".display_en"},  32'(de),  32'(ede));
    cmp({nm, ".frame_end"},   32'(fe),  32'(efe));
    cmp({nm, ".frame_count"}, 32'(fc),  32'(efc));
  endtask

  always @(negedge clk) begin
    model_check("a", 640, 16, 96, 48, 480, 10, 2, 33, 304, 448, n_a,
                if_a.DrawX, if_a.DrawY, if_a.show_base, if_a.hs, if_a.vs,
                if_a.display_en, if_a.frame_end, if_a.frame_count);
    model_check("b", 40, 2, 4, 2, 36, 1, 1, 2, 4, 2, n_b,
                if_b.DrawX, if_b.DrawY, if_b.show_base, if_b.hs, if_b.vs,
                if_b.display_en, if_b.frame_end, if_b.frame_count);
    model_check("c", 4, 1, 1, 1, 3, 1, 1, 2, 0, 0, n_c,
                if_c.DrawX, if_c.DrawY, if_c.show_base, if_c.hs, if_c.vs,
                if_c.display_en, if_c.frame_end, if_c.frame_count);
  end

  function automatic longint cur_n(input int which);
    if (which == 0) return n_a;
    if (which == 1) return n_b;
    return n_c;
  endfunction

  task automatic wait_n(input int which, input longint tgt);
    for (int i = 0; i < 20000; i++) begin
      if (cur_n(which) == tgt) return;
      @(negedge clk);
    end
    total_cnt++;
    $display("FAIL wait_n inst=%0d actual=%0d required=%0d (timeout)", which, cur_n(which), tgt);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int wx[10]  = '{4, 3, 4, 35, 36, 3, 4, 35, 36, 4};
  int wy[10]  = '{1, 2, 2, 2, 2, 33, 33, 33, 33, 34};
  int wsb[10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};

  initial begin
    rst_a = 1'b1;
    rst   = 1'b1;
    #12;
    cmp("rst.DrawX", 32'(if_a.DrawX), 0);
    cmp("rst.DrawY", 32'(if_a.DrawY), 0);
    cmp("rst.hs", 32'(if_a.hs), 1);
    cmp("rst.vs", 32'(if_a.vs), 1);
    cmp("rst.display_en", 32'(if_a.display_en), 0);
    cmp("rst.frame_end", 32'(if_a.frame_end), 0);
    cmp("rst.frame_count", 32'(if_a.frame_count), 0);
    cmp("rst.show_base", 32'(if_a.show_base), 0);
    #10;
    rst_a = 1'b0;
    rst   = 1'b0;

    fork
      begin : inst_a
        int hs_low;
        int first_x;
        wait_n(0, 1);
        cmp("a.first_edge_DrawX", 32'(if_a.DrawX), 1);
        wait_n(0, 800);
        cmp("a.line_wrap_DrawX", 32'(if_a.DrawX), 0);
        cmp("a.line_wrap_DrawY", 32'(if_a.DrawY), 1);
        cmp("a.line_wrap_frame_end", 32'(if_a.frame_end), 0);
        hs_low  = 0;
        first_x = -1;
        for (int i = 0; i < 800; i++) begin
          if (!if_a.hs) begin
            hs_low++;
            if (first_x < 0) first_x = int'(if_a.DrawX);
          end
          @(negedge clk);
        end
        cmp("a.hs_low_cycles", 32'(hs_low), 96);
        cmp("a.hs_first_low_DrawX", 32'(first_x), 657);
        wait_n(0, 2100);
        cmp("a.pre_reset_DrawX", 32'(if_a.DrawX), 500);
        @(posedge clk);
        #2;
        rst_a = 1'b1;
        #1;
        cmp("a.async.DrawX", 32'(if_a.DrawX), 0);
        cmp("a.async.DrawY", 32'(if_a.DrawY), 0);
        cmp("a.async.hs", 32'(if_a.hs), 1);
        cmp("a.async.vs", 32'(if_a.vs), 1);
        cmp("a.async.display_en", 32'(if_a.display_en), 0);
        cmp("a.async.frame_end", 32'(if_a.frame_end), 0);
        cmp("a.async.frame_count", 32'(if_a.frame_count), 0);
        @(negedge clk);
        #1;
        rst_a = 1'b0;
        wait_n(0, 1);
        cmp("a.rerelease_DrawX", 32'(if_a.DrawX), 1);
        cmp("a.rerelease_frame_end", 32'(if_a.frame_end), 0);
      end
      begin : inst_b
        for (int k = 0; k < 10; k++) begin
          wait_n(1, longint'(wy[k] * 48 + wx[k]));
          cmp($sformatf("b.window_x%0d_y%0d", wx[k], wy[k]), 32'(if_b.show_base), 32'(wsb[k]));
        end
      end
      begin : inst_c
        int vs_low;
        int fe_cnt;
        wait_n(2, 49);
        cmp("c.frame1_frame_end", 32'(if_c.frame_end), 1);
        cmp("c.frame1_count", 32'(if_c.frame_count), 1);
        cmp("c.frame1_DrawX", 32'(if_c.DrawX), 0);
        vs_low = 0;
        fe_cnt = 0;
        @(negedge clk);
        while (n_c <= 12544) begin
          if (n_c <= 98 && !if_c.vs) vs_low++;
          if (if_c.frame_end) fe_cnt++;
          if (n_c == 12495) cmp("c.count_255", 32'(if_c.frame_count), 255);
          if (n_c == 12544) begin
            cmp("c.wrap_count", 32'(if_c.frame_count), 0);
            cmp("c.wrap_frame_end", 32'(if_c.frame_end), 1);
          end
          @(negedge clk);
        end
        cmp("c.vs_low_per_frame", 32'(vs_low), 7);
        cmp("c.frame_end_pulses", 32'(fe_cnt), 255);
      end
    join

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, hsync pulse width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels; H_TOTAL = sum of the four horizontal parameters = 800.
REQ-005 Parameter V_VISIBLE, 480, active lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines; V_TOTAL = sum of the four vertical parameters = 525.
REQ-009 Parameter BASE_X, 304, left column of the 32x32 base window.
REQ-010 Parameter BASE_Y, 448, top row of the 32x32 base window.
REQ-011 Port vga_clk, input, 1, pixel clock; all state updates on the rising edge.
REQ-012 Port reset, input, 1, asynchronous, active-high reset.
REQ-013 Port DrawX, output, 10, current horizontal counter value, 0..H_TOTAL-1.
REQ-014 Port DrawY, output, 10, current vertical counter value, 0..V_TOTAL-1.
REQ-015 Port show_base, output, 1, high while (DrawX,DrawY) lies in the base window.
REQ-016 Port hs, output, 1, horizontal sync, active low, pipeline-aligned.
REQ-017 Port vs, output, 1, vertical sync, active low, pipeline-aligned.
REQ-018 Port display_en, output, 1, high for visible pixels, pipeline-aligned.
REQ-019 Port frame_end, output, 1, single-cycle frame wrap pulse.
REQ-020 Port frame_count, output, 8, count of completed frames.

Function
REQ-021 DrawX SHALL increment by 1 every cycle and wrap from H_TOTAL-1 to 0.
REQ-022 DrawY SHALL increment by 1 in the cycle DrawX wraps, wrap from V_TOTAL-1 to 0, and hold otherwise.
REQ-023 DrawX and DrawY SHALL be registered counter outputs, not combinational decodes.
REQ-024 show_base SHALL be combinational from DrawX/DrawY: high iff BASE_X <= DrawX <= BASE_X+31 and BASE_Y <= DrawY <= BASE_Y+31.
REQ-025 Internal raw hsync SHALL be low iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751 at default values).
REQ-026 Internal raw vsync SHALL be low iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491 at default values).
REQ-027 Internal raw display enable SHALL be high iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-028 hs, vs and display_en SHALL equal their raw values delayed by exactly one vga_clk cycle, to align with one-cycle-registered sprite RGB output.
REQ-029 frame_end SHALL be registered: high for exactly one cycle, in the cycle after the counters held (H_TOTAL-1, V_TOTAL-1), which is the cycle they show (0,0).
REQ-030 frame_count SHALL increment by 1 in the same cycle frame_end rises, and wrap from 255 to 0.
REQ-031 All arithmetic SHALL be unsigned 10-bit; window comparisons SHALL not overflow at DrawX or DrawY = 1023.

Reset
REQ-032 While reset is high, outputs SHALL be: DrawX=0, DrawY=0, hs=1, vs=1, display_en=0, frame_end=0, frame_count=0; show_base SHALL follow REQ-024 and is 0.
REQ-033 Reset SHALL take effect immediately on assertion without waiting for a clock edge, including mid-frame.
REQ-034 After reset deasserts, the first rising edge SHALL advance DrawX to 1; frame_end SHALL NOT pulse for the post-reset (0,0).

Verification
REQ-035 Reset, release, clock 800 cycles -> DrawX wraps 799->0, DrawY goes 0->1, frame_end stays 0.
REQ-036 Sample hs over one line -> low in exactly 96 cycles, first low observed while DrawX=657 (one-cycle delay).
REQ-037 Clock one full frame of 420000 cycles -> vs low for 1600 cycles, frame_end pulses once at (0,0), frame_count=1.
REQ-038 Sweep DrawX 303/304/335/336 at DrawY 448 and 479, then DrawY 447/480 at DrawX 304 -> show_base is 0/1/1/0 in each row and 0 at DrawY 447 and 480.
REQ-039 Assert reset asynchronously at DrawX=500, DrawY=200 between clock edges -> all outputs reach their reset values before the next rising edge.
REQ-040 Run 256 frames -> frame_count wraps 255->0 coincident with the 256th frame_end pulse.
